ifq_fetch_ctrl: RTL and testbench
=================================

// Module: ifq_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer sitting between the icache and dispatch.
//  - Issues line-aligned reads to the icache and buffers the returned 128-bit lines in a small FIFO.
//  - Hands 32-bit instructions plus their PC to dispatch, one per accepted read.
//  - On a branch/jump redirect it aborts the icache, flushes the FIFO and refetches.
// PARAMETERS
//  W_DATA     32  instruction / PC width
//  W_LINE     128 icache line width (4 instructions per line)
//  DEPTH      4   line FIFO entries (power of 2, >=2)
//  CACHE_LAT  0   icache read latency in cycles: 0 = combinational, 1 = output register
//  RESET_PC   0   first fetch address after reset
// PORTS
//  clk                 in  1      clock, rising edge
//  reset               in  1      asynchronous, active-high reset
//  ifq_pcin            out 32     fetch address, always line aligned ([3:0]=0)
//  ifq_ren             out 1      icache read request
//  ifq_abort           out 1      icache abort, one-cycle pulse
//  ifq_dout            in  128    icache line data
//  ifq_dout_valid      in  1      icache line valid
//  jmp_branch_address  in  32     redirect target (word aligned)
//  jmp_branch_valid    in  1      redirect strobe
//  dispatch_ren        in  1      dispatch consumes inst/pc_out this cycle
//  inst                out 32     head instruction
//  pc_out              out 32     PC of inst
//  empty               out 1      no valid instruction at head
// BEHAVIOUR
//  Reset values: ifq_ren=0, ifq_abort=0, inst=0, pc_out=0, empty=1, fetch_pc=RESET_PC, FIFO empty, state=RUN.
//  FIFO entry holds {line, line_pc}. rd_word[1:0] selects the word: inst=line[32*rd_word +: 32], pc_out=line_pc+4*rd_word.
//  Issue rule: ifq_ren=1 in RUN when (count + inflight) < DEPTH. fetch_pc += 16 on each issue; wraps 0xFFFF_FFF0 -> 0x0.
//  inflight counts issued reads not yet returned (0..CACHE_LAT).
//  Return rule: ifq_dout_valid pushes {ifq_dout, pc of that request}. A push with the FIFO full is a design error (assertion).
//  Dispatch: when dispatch_ren & ~empty, rd_word++. At rd_word=3 the entry pops and rd_word returns to 0.
//    dispatch_ren while empty is ignored.
//  Redirect (jmp_branch_valid=1):
//    - same cycle: ifq_abort=1, ifq_ren=0; FIFO and rd_word cleared at the edge.
//    - fetch_pc <= {addr[31:4],4'h0}; first_word <= addr[3:2].
//    - drop_cnt <= inflight; state goes to FLUSH if drop_cnt>0, else RUN.
//  First line after a redirect: rd_word starts at first_word, so words below the target are skipped.
//  FLUSH: no issue. Each ifq_dout_valid decrements drop_cnt and is discarded. Return to RUN at 0.
//    A redirect in FLUSH restarts it with drop_cnt = outstanding.
//  Simultaneous redirect + dispatch_ren: the dispatch read completes (head consumed), then the flush applies.
//  Simultaneous push + pop on the last word: both happen, count unchanged.
//  Reset mid-operation: immediately returns to reset values, including outstanding/drop counters.
//    Icache data arriving after reset deasserts is ignored until the first issued read.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//    - FIFO empty and ifq_dout_valid in RUN: the line drives inst/pc_out combinationally in the same cycle (empty=0).
//    - If dispatch_ren is also 1, word rd_word is consumed and the remainder is written to the FIFO.
//  IFQ_BYPASS_EN undefined:
//    - Returned lines are visible the cycle after the push (min fetch->dispatch = CACHE_LAT+1 cycles).
// STRUCTURE
//  Package ifq_pkg:
//    - localparams W_DATA, W_LINE, WORDS_PER_LINE=W_LINE/W_DATA.
//    - typedef ifq_line_t {line, line_pc}.
//    - state enum {RUN, FLUSH}.
//    - function line_align(pc).
//  Sub-module ifq_line_fifo (DEPTH x ifq_line_t, push/pop/flush, count, full/empty).
//    Sequencing, counters and word select stay in the top.
// TESTING
//  1 Reset, CACHE_LAT=0, dispatch_ren=1 held:
//    -> ifq_pcin 0x00,0x10,..; inst/pc_out 0x00,0x04,0x08,... one per cycle after fill.
//  2 dispatch_ren=0, DEPTH=4:
//    -> exactly 4 reads issued, ifq_ren low afterwards.
//    -> one dispatch_ren pulse x4 words re-enables exactly one read.
//  3 Redirect to 0x0000_0128 mid-stream:
//    -> ifq_abort one cycle, empty=1, next ifq_pcin=0x120, first pc_out=0x128, then 0x12C, 0x130.
//  4 CACHE_LAT=1, redirect in the cycle after a read issue:
//    -> that returning line is dropped (never appears on inst), state FLUSH->RUN.
//  5 Redirect + dispatch_ren same cycle, and fetch_pc at 0xFFFF_FFF0:
//    -> head consumed once; next line address 0x0000_0000.
//  6 IFQ_BYPASS_EN, FIFO empty, CACHE_LAT=0:
//    -> inst valid in the issue cycle.
//    -> without the macro, valid one cycle later.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types for the instruction-fetch queue: line/PC record, sequencer
// states and the line-alignment helper.
package ifq_pkg;
    localparam int W_DATA         = 32;
    localparam int W_LINE         = 128;
    localparam int WORDS_PER_LINE = W_LINE / W_DATA;

    typedef struct packed {
        logic [W_LINE-1:0] line;
        logic [W_DATA-1:0] line_pc;
    } ifq_line_t;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} ifq_state_e;

    function automatic logic [W_DATA-1:0] line_align(input logic [W_DATA-1:0] pc);
        return {pc[W_DATA-1:4], 4'h0};
    endfunction
endpackage

// File: rtl/ifq_fetch_ctrl_if.sv
// Icache, redirect and dispatch signals of the fetch sequencer; master is the
// sequencer, slave is the surrounding pipeline.
interface ifq_fetch_ctrl_if;
    import ifq_pkg::*;

    logic [W_DATA-1:0] ifq_pcin;
    logic              ifq_ren;
    logic              ifq_abort;
    logic [W_LINE-1:0] ifq_dout;
    logic              ifq_dout_valid;
    logic [W_DATA-1:0] jmp_branch_address;
    logic              jmp_branch_valid;
    logic              dispatch_ren;
    logic [W_DATA-1:0] inst;
    logic [W_DATA-1:0] pc_out;
    logic              empty;

    modport master (
        output ifq_pcin, ifq_ren, ifq_abort, inst, pc_out, empty,
        input  ifq_dout, ifq_dout_valid, jmp_branch_address, jmp_branch_valid, dispatch_ren
    );

    modport slave (
        input  ifq_pcin, ifq_ren, ifq_abort, inst, pc_out, empty,
        output ifq_dout, ifq_dout_valid, jmp_branch_address, jmp_branch_valid, dispatch_ren
    );
endinterface

// File: rtl/ifq_line_fifo.sv
// Line FIFO of {line, line_pc} records with synchronous flush; storage is not
// reset, only pointers and occupancy.
module ifq_line_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ifq_line_t              wr_data,
    output ifq_line_t              rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    ifq_line_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

    // The issue rule reserves a slot for every outstanding read.
    assert property (@(posedge clk) disable iff (reset) !(push && full && !pop && !flush));
endmodule

// File: rtl/ifq_fetch_ctrl.sv
// Instruction-fetch sequencer: issues line reads, buffers lines, hands out one
// word per dispatch and flushes on redirect. IFQ_BYPASS_EN: same-cycle line bypass.
module ifq_fetch_ctrl
    import ifq_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                CACHE_LAT = 0,
    parameter logic [W_DATA-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         reset,
    ifq_fetch_ctrl_if.master bus
);
    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    ifq_state_e        state;
    logic [W_DATA-1:0] fetch_pc;
    logic [W_DATA-1:0] ret_pc;
    logic [1:0]        rd_word;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     inflight_nxt;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    ifq_line_t         fifo_rd;
    ifq_line_t         wr_data;
    ifq_line_t         head;
    logic              redirect, issue, ret_valid, keep, byp;
    logic              out_empty, do_disp, last, push, pop;
    logic              unused_addr_bits;

    assign redirect = bus.jmp_branch_valid;
    assign issue    = !reset && (state == RUN) && !redirect &&
                      (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C);

    generate
        if (CACHE_LAT == 0) begin : g_lat0
            assign ret_valid    = bus.ifq_dout_valid && issue;
            assign ret_pc       = fetch_pc;
            assign inflight     = '0;
            assign inflight_nxt = '0;
        end else begin : g_lat1
            logic [W_DATA-1:0] req_pc;
            // Returns only count once a read is outstanding, so stale data after reset is ignored.
            assign ret_valid    = bus.ifq_dout_valid && (inflight != '0);
            assign ret_pc       = req_pc;
            assign inflight_nxt = inflight + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, ret_valid};
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    inflight <= '0;
                    req_pc   <= '0;
                end else begin
                    inflight <= inflight_nxt;
                    if (issue) req_pc <= fetch_pc;
                end
            end
        end
    endgenerate

    assign keep    = ret_valid && (state == RUN) && !redirect;
    assign wr_data = ifq_line_t'{line: bus.ifq_dout, line_pc: ret_pc};

`ifdef IFQ_BYPASS_EN
    assign byp = keep && fifo_empty;
`else
    assign byp = 1'b0;
`endif

    assign head      = byp ? wr_data : fifo_rd;
    assign out_empty = fifo_empty && !byp;
    assign do_disp   = bus.dispatch_ren && !out_empty;
    assign last      = (rd_word == 2'(WORDS_PER_LINE - 1));
    assign pop       = do_disp && last && !byp;
    // A bypassed line that is fully consumed on arrival never enters the FIFO.
    assign push      = keep && !(byp && do_disp && last);

    assign bus.ifq_pcin  = fetch_pc;
    assign bus.ifq_ren   = issue;
    assign bus.ifq_abort = redirect && !reset;
    assign bus.empty     = out_empty;
    assign bus.inst      = out_empty ? '0 : head.line[W_DATA*rd_word +: W_DATA];
    assign bus.pc_out    = out_empty ? '0 : head.line_pc + {{(W_DATA-4){1'b0}}, rd_word, 2'b00};

    assign unused_addr_bits = ^bus.jmp_branch_address[1:0];

    ifq_line_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (wr_data),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            rd_word  <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            // The first line after a redirect starts at the target word.
            fetch_pc <= line_align(bus.jmp_branch_address);
            rd_word  <= bus.jmp_branch_address[3:2];
            drop_cnt <= inflight_nxt;
            state    <= (inflight_nxt != '0) ? FLUSH : RUN;
        end else begin
            if (issue)   fetch_pc <= fetch_pc + W_DATA'(16);
            if (do_disp) rd_word  <= last ? 2'd0 : rd_word + 2'd1;
            if ((state == FLUSH) && ret_valid) begin
                drop_cnt <= drop_cnt - 1'b1;
                if (drop_cnt == CW'(1)) state <= RUN;
            end
        end
    end

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Directed bench for ifq_fetch_ctrl: one instance with a combinational icache,
// one with a registered icache that can be held back by one cycle.
module tb_ifq_fetch_ctrl;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic hold1;
    logic v1;
    logic [31:0] a1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifq_fetch_ctrl_if if0 ();
    ifq_fetch_ctrl_if if1 ();

    ifq_fetch_ctrl #(.DEPTH(4), .CACHE_LAT(0), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.master));
    ifq_fetch_ctrl #(.DEPTH(4), .CACHE_LAT(1), .RESET_PC(32'h0)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.master));

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = a + 32'h1000_0000 + 32'(4 * k);
        return l;
    endfunction

    always_comb begin
        if0.ifq_dout       = line_of(if0.ifq_pcin);
        if0.ifq_dout_valid = if0.ifq_ren;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            a1 <= '0;
        end else if (!hold1) begin
            v1 <= if1.ifq_ren;
            a1 <= if1.ifq_pcin;
        end
    end

    always_comb begin
        if1.ifq_dout       = line_of(a1);
        if1.ifq_dout_valid = v1 && !hold1;
    end

    typedef struct {
        logic        rst, disp, jv;
        logic [31:0] ja;
        logic        ren;
        logic [31:0] pcin;
        logic        abort, emp;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, disp, jv, input logic [31:0] ja,
                       input logic ren, input logic [31:0] pcin,
                       input logic abort, emp, input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.disp = disp; v.jv = jv; v.ja = ja; v.ren = ren;
        v.pcin = pcin; v.abort = abort; v.emp = emp; v.pc = pc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc1(input logic disp, input logic jv, input logic [31:0] ja, input logic hold);
        @(negedge clk);
        if1.dispatch_ren       = disp;
        if1.jmp_branch_valid   = jv;
        if1.jmp_branch_address = ja;
        hold1                  = hold;
        #1;
    endtask

    task automatic cyc0(input logic disp);
        @(negedge clk);
        if0.dispatch_ren = disp;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        hold1 = 1'b0;
        if0.dispatch_ren = 1'b0; if0.jmp_branch_valid = 1'b0; if0.jmp_branch_address = '0;
        if1.dispatch_ren = 1'b0; if1.jmp_branch_valid = 1'b0; if1.jmp_branch_address = '0;

`ifndef IFQ_BYPASS_EN
        // rst disp jv  addr          ren pcin          abort emp pc_out
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0);
        // streaming with dispatch held high
        add(0, 1, 0, 32'h0,         1, 32'h00,        0, 1, 32'h0);
        add(0, 1, 0, 32'h0,         1, 32'h10,        0, 0, 32'h00);
        add(0, 1, 0, 32'h0,         1, 32'h20,        0, 0, 32'h04);
        add(0, 1, 0, 32'h0,         1, 32'h30,        0, 0, 32'h08);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0C);
        add(0, 1, 0, 32'h0,         1, 32'h40,        0, 0, 32'h10);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h14);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h18);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h1C);
        add(0, 1, 0, 32'h0,         1, 32'h50,        0, 0, 32'h20);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0);
        // no dispatch: fill to DEPTH, then one line's worth of dispatch frees one read
        add(0, 0, 0, 32'h0,         1, 32'h00,        0, 1, 32'h0);
        add(0, 0, 0, 32'h0,         1, 32'h10,        0, 0, 32'h0);
        add(0, 0, 0, 32'h0,         1, 32'h20,        0, 0, 32'h0);
        add(0, 0, 0, 32'h0,         1, 32'h30,        0, 0, 32'h0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h00);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h04);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h08);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0C);
        add(0, 0, 0, 32'h0,         1, 32'h40,        0, 0, 32'h10);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h10);
        // redirect to 0x128 mid-stream
        add(0, 0, 1, 32'h128,       0, 32'h0,         1, 0, 32'h10);
        add(0, 1, 0, 32'h0,         1, 32'h120,       0, 1, 32'h0);
        add(0, 1, 0, 32'h0,         1, 32'h130,       0, 0, 32'h128);
        add(0, 1, 0, 32'h0,         1, 32'h140,       0, 0, 32'h12C);
        add(0, 1, 0, 32'h0,         1, 32'h150,       0, 0, 32'h130);
        // redirect together with dispatch, then fetch address wraps
        add(0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,         1, 0, 32'h134);
        add(0, 0, 0, 32'h0,         1, 32'hFFFF_FFF0, 0, 1, 32'h0);
        add(0, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 0, 32'hFFFF_FFF8);
        add(0, 1, 0, 32'h0,         1, 32'h10,        0, 0, 32'hFFFF_FFFC);
        add(0, 1, 0, 32'h0,         1, 32'h20,        0, 0, 32'h0000_0000);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset                  = tbl[i].rst;
            if0.dispatch_ren       = tbl[i].disp;
            if0.jmp_branch_valid   = tbl[i].jv;
            if0.jmp_branch_address = tbl[i].ja;
            #1;
            chk($sformatf("row%0d.ren", i),    {31'b0, if0.ifq_ren},   {31'b0, tbl[i].ren});
            chk($sformatf("row%0d.abort", i),  {31'b0, if0.ifq_abort}, {31'b0, tbl[i].abort});
            chk($sformatf("row%0d.empty", i),  {31'b0, if0.empty},     {31'b0, tbl[i].emp});
            chk($sformatf("row%0d.pc_out", i), if0.pc_out, tbl[i].pc);
            chk($sformatf("row%0d.inst", i),   if0.inst,
                tbl[i].emp ? 32'h0 : tbl[i].pc + 32'h1000_0000);
            if (tbl[i].ren) chk($sformatf("row%0d.pcin", i), if0.ifq_pcin, tbl[i].pcin);
        end
        @(negedge clk);
        if0.dispatch_ren = 1'b0; if0.jmp_branch_valid = 1'b0; if0.jmp_branch_address = '0;
`endif

        // registered icache: dropped lines on redirect, with and without a held return
        pulse_reset();
        chk("lat1.rst.ren",   {31'b0, if1.ifq_ren},   32'h0);
        chk("lat1.rst.abort", {31'b0, if1.ifq_abort}, 32'h0);
        chk("lat1.rst.empty", {31'b0, if1.empty},     32'h1);
        chk("lat1.rst.inst",  if1.inst,   32'h0);
        chk("lat1.rst.pc",    if1.pc_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("lat1.c0.ren",  {31'b0, if1.ifq_ren}, 32'h1);
        chk("lat1.c0.pcin", if1.ifq_pcin, 32'h0);
        cyc1(1'b0, 1'b1, 32'h200, 1'b0);
        chk("lat1.c1.abort", {31'b0, if1.ifq_abort}, 32'h1);
        chk("lat1.c1.ren",   {31'b0, if1.ifq_ren},   32'h0);
        cyc1(1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat1.c2.empty", {31'b0, if1.empty}, 32'h1);
        chk("lat1.c2.pcin",  if1.ifq_pcin, 32'h200);
        chk("lat1.c2.ren",   {31'b0, if1.ifq_ren}, 32'h1);
        cyc1(1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat1.c3.empty", {31'b0, if1.empty}, BYP ? 32'h0 : 32'h1);
        cyc1(1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat1.c4.empty", {31'b0, if1.empty}, 32'h0);
        chk("lat1.c4.pc",    if1.pc_out, 32'h200);
        chk("lat1.c4.inst",  if1.inst,   32'h1000_0200);
        cyc1(1'b0, 1'b1, 32'h300, 1'b1);
        chk("lat1.c5.abort", {31'b0, if1.ifq_abort}, 32'h1);
        cyc1(1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat1.c6.flush_ren", {31'b0, if1.ifq_ren}, 32'h0);
        chk("lat1.c6.empty",     {31'b0, if1.empty},   32'h1);
        cyc1(1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat1.c7.ren",   {31'b0, if1.ifq_ren}, 32'h1);
        chk("lat1.c7.pcin",  if1.ifq_pcin, 32'h300);
        chk("lat1.c7.empty", {31'b0, if1.empty}, 32'h1);
        cyc1(1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat1.c8.empty", {31'b0, if1.empty}, BYP ? 32'h0 : 32'h1);
        cyc1(1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat1.c9.empty", {31'b0, if1.empty}, 32'h0);
        chk("lat1.c9.pc",    if1.pc_out, 32'h300);

        // fetch-to-dispatch latency with an empty FIFO
        pulse_reset();
        chk("byp.rst.empty", {31'b0, if0.empty}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        if0.dispatch_ren = 1'b1;
        #1;
        chk("byp.c0.empty", {31'b0, if0.empty}, BYP ? 32'h0 : 32'h1);
        chk("byp.c0.inst",  if0.inst, BYP ? 32'h1000_0000 : 32'h0);
        cyc0(1'b1);
        chk("byp.c1.empty", {31'b0, if0.empty}, 32'h0);
        chk("byp.c1.pc",    if0.pc_out, BYP ? 32'h4 : 32'h0);
        cyc0(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
